polyvec_loader: RTL
===================

Name: polyvec_loader

Overview:
- Upstream feeder for the four-bank polynomial-vector RAM (one bank per polynomial, one coefficient per bank per address).
- Accepts a valid/ready stream of coefficients in address-interleaved order (addr n: poly0, poly1, …, poly(K-1)) and reduces each coefficient once modulo q = 3329.
- Groups K coefficients into one four-lane write word and issues one RAM write per address, sweeping addresses 0..depth-1.
- Signals completion with a single-cycle done pulse.

Parameters:
- addr_width, 8, RAM address width.
- depth, 256, number of addresses per load; must be ≤ 2^addr_width.
- data_width, 12, coefficient width.
- KYBER_Q, 3329, modulus for the conditional subtraction.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- k_num  input  3  polynomials per address. Values 2, 3 and 4 are used as given; any other value is treated as 4. Sampled on an accepted start.
- s_valid  input  1  input coefficient valid.
- s_data  input  data_width  input coefficient, unsigned.
- s_ready  output  1  loader accepts a coefficient this cycle.
- wen  output  1  RAM write enable; registered.
- waddr  output  addr_width  RAM write address; registered.
- din0, din1, din2, din3  output  data_width each  RAM write data, one per bank; registered.
- busy  output  1  high from the cycle after an accepted start until done is asserted.
- done  output  1  one-cycle pulse after the final write.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; s_ready, wen, busy, done = 0; waddr = 0; din0..3 = 0; lane and address counters = 0; latched K = 4.
- States:
  - IDLE: start=1 → latch K, clear counters, go to LOAD.
  - LOAD: s_ready = 1. While in LOAD, start is ignored.
  - FLUSH: entered after the last coefficient of the last address is accepted; lasts one cycle while the final write is issued.
  - DONE: done = 1 for exactly one cycle, then return to IDLE.
- busy = 1 in LOAD and FLUSH.
- Transfer: a coefficient is accepted when s_valid & s_ready.
  - Reduce: r = s_data − KYBER_Q if s_data ≥ KYBER_Q, else s_data. The result is always < 3329 for a 12-bit input.
  - Store r into lane register [lane]; lane increments by 1.
- Group complete: when the accepted coefficient is lane K−1:
  - Next cycle: wen = 1, waddr = current address counter.
  - din0..3 = lane registers, including this cycle's r; lanes ≥ K are driven as 0.
  - Lane resets to 0; address counter increments.
  - Lane registers are cleared after each write, so stale values never leak into unused lanes.
- Write latency: exactly 1 cycle after the last accepted coefficient of a group. wen is high for exactly one cycle per address and is never asserted outside LOAD/FLUSH.
- Final address: when address depth−1 completes, the next cycle issues the write and enters FLUSH. s_ready = 0 from that cycle onward. The cycle after FLUSH is DONE.
- Address counter: no wrap-around within a load; each load writes exactly depth addresses, starting at 0.
- s_valid gaps: the loader holds its state indefinitely; there is no timeout.
- The RAM does not back-pressure; wen is never stalled.
- start in the same cycle as done: ignored, because the block is not in IDLE.
- Reset mid-load: the partial group is discarded and no further write is issued. Addresses already written are not rolled back.

Test Plan:
- Reset, then start with k_num=4 and stream 1024 coefficients of value i mod 3329 with s_valid held high → 256 writes; waddr n carries din0..3 = the 4n..4n+3 stream values; done high at cycle 1026 after start.
- k_num=2: stream pairs (100, 200) → every write has din0=100, din1=200, din2=0, din3=0; 256 writes; done pulses once.
- Reduction: inputs 3328, 3329, 4095, 0 (k_num=4) → din = 3328, 0, 766, 0 at waddr 0.
- Random s_valid gaps, k_num=3 → identical write sequence to the gap-free run; no wen while a group is incomplete; s_ready=0 after the final coefficient.
- Assert rst after 10 coefficients (k_num=4) → outputs return to reset values immediately; a new start loads from waddr 0 with correct lane alignment.
- k_num=7 → behaves as k_num=4; start pulsed during LOAD → ignored, no restart, and waddr continues incrementing.

Source files
------------

// File: rtl/polyvec_loader.sv
// polyvec_loader
// Upstream feeder for a four-bank polynomial-vector RAM. Coefficients arrive
// on a valid/ready stream in address-interleaved order. Each one is reduced
// once modulo KYBER_Q and collected into a lane register. When K coefficients
// have been gathered, one registered four-lane RAM write is issued. Addresses
// 0..depth-1 are swept, and completion is signalled with a one-cycle done pulse.
//
// Ports
//   clk, rst          : system clock, asynchronous active-high reset
//   start             : one-cycle load request (honoured only while idle)
//   k_num[2:0]        : polynomials per address (2, 3 or 4; anything else = 4)
//   s_valid, s_data   : input coefficient stream
//   s_ready           : loader accepts a coefficient this cycle
//   wen, waddr        : registered RAM write enable / address
//   din0..din3        : registered RAM write data, one lane per bank
//   busy              : load in progress (LOAD or FLUSH)
//   done              : one-cycle pulse after the final write
module polyvec_loader #(
  parameter int addr_width = 8,
  parameter int depth      = 256,
  parameter int data_width = 12,
  parameter int KYBER_Q    = 3329
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            k_num,
  input  logic                  s_valid,
  input  logic [data_width-1:0] s_data,
  output logic                  s_ready,
  output logic                  wen,
  output logic [addr_width-1:0] waddr,
  output logic [data_width-1:0] din0,
  output logic [data_width-1:0] din1,
  output logic [data_width-1:0] din2,
  output logic [data_width-1:0] din3,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  localparam logic [data_width-1:0] Q_VAL     = data_width'(KYBER_Q);
  localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(depth - 1);

  state_t                state_q, state_d;
  logic [2:0]            k_q, k_d;
  logic [1:0]            lane_q, lane_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [data_width-1:0] lanes_q [4];
  logic [data_width-1:0] lanes_d [4];
  logic                  wen_q, wen_d;
  logic [addr_width-1:0] waddr_q, waddr_d;
  logic [data_width-1:0] din_q [4];
  logic [data_width-1:0] din_d [4];

  logic [data_width-1:0] reduced;
  logic                  accept;
  logic                  group_done;

  // A single conditional subtraction is enough: a 12-bit input is below 2*q.
  assign reduced    = (s_data >= Q_VAL) ? (s_data - Q_VAL) : s_data;
  assign accept     = s_valid && (state_q == LOAD);
  assign group_done = accept && ({1'b0, lane_q} == (k_q - 3'd1));

  // Next-state logic. When a group completes, the write word is assembled
  // from the stored lanes plus the coefficient arriving this cycle. The lane
  // registers are cleared at the same time, so unused lanes never carry stale data.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    lanes_d = lanes_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    din_d   = din_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          k_d     = (k_num == 3'd2 || k_num == 3'd3 || k_num == 3'd4) ? k_num : 3'd4;
          lane_d  = '0;
          addr_d  = '0;
          for (int i = 0; i < 4; i++) lanes_d[i] = '0;
        end
      end
      LOAD: begin
        if (group_done) begin
          wen_d   = 1'b1;
          waddr_d = addr_q;
          addr_d  = addr_q + addr_width'(1);
          lane_d  = '0;
          for (int i = 0; i < 4; i++) begin
            if (3'(i) >= k_q)          din_d[i] = '0;
            else if (2'(i) == lane_q)  din_d[i] = reduced;
            else                       din_d[i] = lanes_q[i];
            lanes_d[i] = '0;
          end
          if (addr_q == LAST_ADDR) state_d = FLUSH;
        end else if (accept) begin
          lanes_d[lane_q] = reduced;
          lane_d          = lane_q + 2'd1;
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset discards any partial group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= 3'd4;
      lane_q  <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      for (int i = 0; i < 4; i++) begin
        lanes_q[i] <= '0;
        din_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      for (int i = 0; i < 4; i++) begin
        lanes_q[i] <= lanes_d[i];
        din_q[i]   <= din_d[i];
      end
    end
  end

  assign s_ready = (state_q == LOAD);
  assign busy    = (state_q == LOAD) || (state_q == FLUSH);
  assign done    = (state_q == DONE);
  assign wen     = wen_q;
  assign waddr   = waddr_q;
  assign din0    = din_q[0];
  assign din1    = din_q[1];
  assign din2    = din_q[2];
  assign din3    = din_q[3];

endmodule
